// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and constants for the ITCM port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_port_arbiter_pkg;

    // Arbiter FSM states: fetch-priority, one-cycle ext fairness slot, ext locked ownership
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXT   = 2'd1,
        S_LOCK  = 2'd2
    } arb_state_e;

    // Owner of the SRAM read issued last cycle, used to steer mem_rdata
    typedef enum logic [1:0] {
        RD_NONE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_EXT   = 2'd2
    } rd_owner_e;

    // Width of the fetch/ext contention performance counter
    localparam int CONFLICT_CNT_W = 32;

endpackage

// File: rtl/imem_port_arbiter_en_cnt.sv
// Saturating event counter: counts cycles where en is high.
// Latency: count visible one cycle after the enabled cycle.
// Backpressure: none; saturates at all-ones instead of wrapping.
module imem_port_arbiter_en_cnt
    import imem_port_arbiter_pkg::*;
#(
    parameter int W = CONFLICT_CNT_W
) (
    input  logic         cpu_clk,
    input  logic         cpu_rstn,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment on each enabled cycle, holding at the maximum value
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port ITCM between instruction fetch and an external (debug/loader) port.
// Latency: grant is combinational; read data returns one cycle after the grant.
// Backpressure: a denied fetch sees fetch_rvalid=0 and re-presents its PC; ext holds its beat until ext_gnt.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 14,
    parameter int STARVE_MAX = 8
) (
    input  logic                      cpu_clk,
    input  logic                      cpu_rstn,
    input  logic                      dbg_mode,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_rvalid,
    output logic [DATA_WIDTH-1:0]     fetch_rdata,
    input  logic                      ext_req,
    input  logic                      ext_we,
    input  logic                      ext_lock,
    input  logic [ADDR_WIDTH-1:0]     ext_addr,
    input  logic [DATA_WIDTH-1:0]     ext_wdata,
    input  logic [3:0]                ext_be,
    output logic                      ext_gnt,
    output logic                      ext_rvalid,
    output logic [DATA_WIDTH-1:0]     ext_rdata,
    output logic                      mem_cs,
    output logic                      mem_we,
    output logic [3:0]                mem_be,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    localparam int                    STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [STARVE_W-1:0]   STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e           state_q, state_d;
    rd_owner_e            rd_owner_q, rd_owner_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 fetch_gnt;
    logic                 ext_gnt_c;

    // Byte-offset and out-of-ITCM address bits carry no meaning for the word-addressed macro
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr[ADDR_WIDTH-1:MEM_AW+2], fetch_addr[1:0],
                                ext_addr[ADDR_WIDTH-1:MEM_AW+2], ext_addr[1:0]};

    // Grant decision for the current cycle, driven by the registered arbitration state
    always_comb begin
        fetch_gnt = 1'b0;
        ext_gnt_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                // dbg_mode is looked at combinationally so a halt takes effect immediately
                ext_gnt_c = ext_req && (dbg_mode || !fetch_req || (starve_q == STARVE_LIM));
                fetch_gnt = fetch_req && !ext_gnt_c;
            end
            S_EXT: begin
                fetch_gnt = fetch_req;
                ext_gnt_c = ext_req && !fetch_req;
            end
            S_LOCK: begin
                // The unlocking beat itself is still served; fetch waits one more cycle
                ext_gnt_c = ext_req;
            end
            default: begin
                fetch_gnt = 1'b0;
                ext_gnt_c = 1'b0;
            end
        endcase
    end

    // Next-state, starvation counter and read-owner tracking
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (ext_gnt_c) begin
                    state_d = ext_lock ? S_LOCK : S_EXT;
                end
            end
            S_EXT:   state_d = S_FETCH;
            S_LOCK:  state_d = (ext_req && ext_lock) ? S_LOCK : S_FETCH;
            default: state_d = S_FETCH;
        endcase

        starve_d = starve_q;
        if (ext_gnt_c) begin
            starve_d = '0;
        end else if (ext_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        rd_owner_d = RD_NONE;
        if (fetch_gnt) begin
            rd_owner_d = RD_FETCH;
        end else if (ext_gnt_c && !ext_we) begin
            rd_owner_d = RD_EXT;
        end
    end

    // Arbitration state registers; reset drops any read in flight
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q    <= S_FETCH;
            starve_q   <= '0;
            rd_owner_q <= RD_NONE;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // SRAM request mux; all-zero when nobody is granted
    assign ext_gnt   = ext_gnt_c;
    assign mem_cs    = fetch_gnt || ext_gnt_c;
    assign mem_we    = ext_gnt_c && ext_we;
    assign mem_be    = (ext_gnt_c && ext_we)        ? ext_be :
                       (ext_gnt_c || fetch_gnt)     ? 4'hF   : 4'h0;
    assign mem_addr  = ext_gnt_c ? ext_addr[MEM_AW+1:2] :
                       fetch_gnt ? fetch_addr[MEM_AW+1:2] : '0;
    assign mem_wdata = (ext_gnt_c && ext_we) ? ext_wdata : '0;

    // Read return: data is shared, the valid tells each requester whether it is theirs
    assign fetch_rvalid = (rd_owner_q == RD_FETCH);
    assign ext_rvalid   = (rd_owner_q == RD_EXT);
    assign fetch_rdata  = mem_rdata;
    assign ext_rdata    = mem_rdata;

    imem_port_arbiter_en_cnt #(
        .W (CONFLICT_CNT_W)
    ) u_arb_conflict_cnt (
        .cpu_clk  (cpu_clk),
        .cpu_rstn (cpu_rstn),
        .en       (fetch_req && ext_req),
        .cnt      (conflict_cnt)
    );

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 1-cycle SRAM model and read-data scoreboards.
// Latency: expects read data one cycle after each grant.
// Backpressure: checks denied cycles, starvation forcing, lock ownership and reset drop.
module tb_imem_port_arbiter;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        dbg_mode;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ext_req;
    logic        ext_we;
    logic        ext_lock;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_be;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] conflict_cnt;

    logic        preload;
    logic [31:0] sram [0:16383];
    logic [31:0] fetch_q [$];
    logic [31:0] ext_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 cpu_clk = ~cpu_clk;

    imem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_AW     (14),
        .STARVE_MAX (8)
    ) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rstn     (cpu_rstn),
        .dbg_mode     (dbg_mode),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .ext_req      (ext_req),
        .ext_we       (ext_we),
        .ext_lock     (ext_lock),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_be       (ext_be),
        .ext_gnt      (ext_gnt),
        .ext_rvalid   (ext_rvalid),
        .ext_rdata    (ext_rdata),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    function automatic logic [31:0] init_word(input logic [13:0] w);
        if (w == 14'h100) return 32'h11223344;
        return 32'hC0DE0000 | {18'd0, w};
    endfunction

    // Single-port SRAM: one-cycle read latency, byte-enabled writes
    always @(posedge cpu_clk) begin
        if (preload) begin
            for (int i = 0; i < 16384; i++) sram[i] <= init_word(14'(i));
            mem_rdata <= '0;
        end else if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then pop/compare any read data returned
    task automatic next();
        @(negedge cpu_clk);
        #1;
        if (fetch_rvalid === 1'b1) begin
            if (fetch_q.size() == 0) chk("fetch_unexpected_rvalid", 32'(fetch_rvalid), 32'd0);
            else                     chk("fetch_rdata", fetch_rdata, fetch_q.pop_front());
        end
        if (ext_rvalid === 1'b1) begin
            if (ext_q.size() == 0) chk("ext_unexpected_rvalid", 32'(ext_rvalid), 32'd0);
            else                   chk("ext_rdata", ext_rdata, ext_q.pop_front());
        end
    endtask

    task automatic drive(input logic f_req, input logic [31:0] f_addr,
                         input logic e_req, input logic e_we, input logic e_lock,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_be, input logic dbg);
        fetch_req  = f_req;
        fetch_addr = f_addr;
        ext_req    = e_req;
        ext_we     = e_we;
        ext_lock   = e_lock;
        ext_addr   = e_addr;
        ext_wdata  = e_wdata;
        ext_be     = e_be;
        dbg_mode   = dbg;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpu_rstn = 1'b0;
        preload  = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        next();
        next();
        chk("rst_fetch_rvalid", 32'(fetch_rvalid), 0);
        chk("rst_ext_rvalid",   32'(ext_rvalid), 0);
        chk("rst_ext_gnt",      32'(ext_gnt), 0);
        chk("rst_mem_cs",       32'(mem_cs), 0);
        chk("rst_conflict_cnt", conflict_cnt, 0);
        preload  = 1'b0;
        cpu_rstn = 1'b1;

        // Plain sequential fetch
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        chk("f0_cs", 32'(mem_cs), 1);
        chk("f0_addr", 32'(mem_addr), 32'h40);
        chk("f0_we", 32'(mem_we), 0);
        chk("f0_be", 32'(mem_be), 32'hF);
        chk("f0_ext_gnt", 32'(ext_gnt), 0);
        fetch_q.push_back(init_word(14'h40));
        next();
        drive(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        chk("f1_rvalid", 32'(fetch_rvalid), 1);
        chk("f1_addr", 32'(mem_addr), 32'h41);
        fetch_q.push_back(init_word(14'h41));
        next();
        drive(1, 32'h108, 0, 0, 0, 0, 0, 0, 0);
        chk("f2_rvalid", 32'(fetch_rvalid), 1);
        chk("f2_addr", 32'(mem_addr), 32'h42);
        fetch_q.push_back(init_word(14'h42));
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("f3_rvalid", 32'(fetch_rvalid), 1);
        chk("idle_cs", 32'(mem_cs), 0);
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_rvalid", 32'(fetch_rvalid), 0);
        next();

        // Contention: ext starved for 8 cycles, forced on the 9th
        for (int i = 1; i <= 8; i++) begin
            drive(1, 32'h100, 1, 0, 0, 32'h200, 0, 0, 0);
            chk("starve_deny", 32'(ext_gnt), 0);
            chk("starve_fetch_addr", 32'(mem_addr), 32'h40);
            if (i > 1) chk("starve_fetch_rvalid", 32'(fetch_rvalid), 1);
            fetch_q.push_back(init_word(14'h40));
            next();
        end
        drive(1, 32'h100, 1, 0, 0, 32'h200, 0, 0, 0);
        chk("starve_force_gnt", 32'(ext_gnt), 1);
        chk("starve_force_addr", 32'(mem_addr), 32'h80);
        chk("starve_force_we", 32'(mem_we), 0);
        chk("starve_last_fetch_rvalid", 32'(fetch_rvalid), 1);
        ext_q.push_back(init_word(14'h80));
        next();
        drive(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
        chk("fetch_lost_slot", 32'(fetch_rvalid), 0);
        chk("ext_read_rvalid", 32'(ext_rvalid), 1);
        chk("fetch_regain_addr", 32'(mem_addr), 32'h41);
        fetch_q.push_back(init_word(14'h41));
        next();
        drive(1, 32'h104, 1, 0, 0, 32'h200, 0, 0, 0);
        chk("starve_cleared", 32'(ext_gnt), 0);
        chk("fetch_regain_rvalid", 32'(fetch_rvalid), 1);
        chk("ext_rvalid_single", 32'(ext_rvalid), 0);
        fetch_q.push_back(init_word(14'h41));
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("contention_tail_rvalid", 32'(fetch_rvalid), 1);
        next();

        // Debug mode: ext write wins immediately, then read back
        drive(1, 32'h100, 1, 1, 0, 32'h300, 32'hDEADBEEF, 4'hF, 1);
        chk("dbg_same_cycle_gnt", 32'(ext_gnt), 1);
        chk("dbg_wr_we", 32'(mem_we), 1);
        chk("dbg_wr_addr", 32'(mem_addr), 32'hC0);
        chk("dbg_wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("dbg_wr_be", 32'(mem_be), 32'hF);
        next();
        drive(1, 32'h100, 1, 0, 0, 32'h300, 0, 0, 1);
        chk("fairness_fetch_first", 32'(ext_gnt), 0);
        chk("no_rvalid_on_write", 32'(ext_rvalid), 0);
        chk("dbg_denied_fetch", 32'(fetch_rvalid), 0);
        chk("fairness_addr", 32'(mem_addr), 32'h40);
        fetch_q.push_back(init_word(14'h40));
        next();
        drive(1, 32'h100, 1, 0, 0, 32'h300, 0, 0, 1);
        chk("dbg_rd_gnt", 32'(ext_gnt), 1);
        chk("dbg_rd_addr", 32'(mem_addr), 32'hC0);
        chk("dbg_fetch_rvalid", 32'(fetch_rvalid), 1);
        ext_q.push_back(32'hDEADBEEF);
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dbg_rd_rvalid", 32'(ext_rvalid), 1);
        chk("dbg_fetch_stalled", 32'(fetch_rvalid), 0);
        next();

        // Locked burst of four writes; fetch is shut out throughout
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100, 1, 1, 1, 32'(4 * i), 32'hA0 + 32'(i), 4'hF, (i == 0));
            chk("lock_gnt", 32'(ext_gnt), 1);
            chk("lock_addr", 32'(mem_addr), 32'(i));
            chk("lock_fetch_stall", 32'(fetch_rvalid), 0);
            next();
        end
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        chk("lock_release_idle_cs", 32'(mem_cs), 0);
        chk("lock_last_fetch_stall", 32'(fetch_rvalid), 0);
        next();
        drive(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        chk("fetch_after_lock_cs", 32'(mem_cs), 1);
        chk("fetch_after_lock_addr", 32'(mem_addr), 0);
        chk("fetch_after_release_rvalid", 32'(fetch_rvalid), 0);
        fetch_q.push_back(32'hA0);
        next();
        drive(1, 32'hC, 0, 0, 0, 0, 0, 0, 0);
        chk("lock_readback0_rvalid", 32'(fetch_rvalid), 1);
        fetch_q.push_back(32'hA3);
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lock_readback3_rvalid", 32'(fetch_rvalid), 1);
        next();

        // Partial byte write followed by fetch of the same word
        drive(0, 0, 1, 1, 0, 32'h400, 32'h0000AB00, 4'b0010, 0);
        chk("byte_wr_gnt", 32'(ext_gnt), 1);
        chk("byte_wr_be", 32'(mem_be), 32'h2);
        chk("byte_wr_addr", 32'(mem_addr), 32'h100);
        next();
        drive(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        chk("byte_rd_addr", 32'(mem_addr), 32'h100);
        fetch_q.push_back(32'h1122AB44);
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("byte_rd_rvalid", 32'(fetch_rvalid), 1);
        next();

        // Reset while an ext read is in flight
        drive(0, 0, 1, 0, 0, 32'h200, 0, 0, 0);
        chk("rst_pre_gnt", 32'(ext_gnt), 1);
        chk("conflict_cnt_pre_rst", conflict_cnt, 32'd17);
        cpu_rstn = 1'b0;
        #1;
        chk("rst_cnt_clear", conflict_cnt, 0);
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_drop_read", 32'(ext_rvalid), 0);
        chk("rst_fetch_rvalid_mid", 32'(fetch_rvalid), 0);
        next();
        cpu_rstn = 1'b1;
        drive(1, 32'h100, 1, 0, 0, 32'h200, 0, 0, 0);
        chk("rst_state_fetch", 32'(ext_gnt), 0);
        chk("rst_fetch_addr", 32'(mem_addr), 32'h40);
        chk("rst_no_late_rvalid", 32'(ext_rvalid), 0);
        fetch_q.push_back(init_word(14'h40));
        next();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_fetch_rvalid", 32'(fetch_rvalid), 1);
        chk("post_rst_ext_rvalid", 32'(ext_rvalid), 0);
        chk("post_rst_conflict_cnt", conflict_cnt, 32'd1);
        next();

        chk("fetch_q_drained", 32'(fetch_q.size()), 0);
        chk("ext_q_drained", 32'(ext_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
